// File: rtl/ram_tx_streamer.sv
// ram_tx_streamer: streams IMG_BYTES bytes from byte RAM into uart_tx via its DV/Done handshake
module ram_tx_streamer #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 8,
  parameter int IMG_BYTES = 262144,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              busy,
  output logic              fin,
  output logic [ADDR_W:0]   bytes_sent
);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAT_INIT = CW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_BYTES - 1);
  typedef enum logic [2:0] {IDLE, RD, ARM, WAIT, DONE} state_t;
  state_t state;
  logic [CW-1:0] lat_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      ram_addr   <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      fin        <= 1'b0;
      bytes_sent <= '0;
    end else begin
      tx_dv <= 1'b0;
      if (abort) begin
        // an in-flight frame keeps running in uart_tx; its tx_done lands outside WAIT
        state    <= IDLE;
        lat_cnt  <= '0;
        ram_addr <= '0;
        tx_byte  <= '0;
        busy     <= 1'b0;
        fin      <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state      <= RD;
            lat_cnt    <= LAT_INIT;
            ram_addr   <= '0;
            bytes_sent <= '0;
            busy       <= 1'b1;
            fin        <= 1'b0;
          end
          RD: if (lat_cnt == '0) begin
            tx_byte <= ram_q;
            state   <= ARM;
          end else lat_cnt <= lat_cnt - 1'b1;
          ARM: if (!tx_active) begin
            tx_dv <= 1'b1;
            state <= WAIT;
          end
          WAIT: if (tx_done) begin
            bytes_sent <= bytes_sent + 1'b1;
            if (ram_addr == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              fin   <= 1'b1;
            end else begin
              ram_addr <= ram_addr + 1'b1;
              lat_cnt  <= LAT_INIT;
              state    <= RD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ram_tx_streamer.sv
// tb_ram_tx_streamer: three streamer instances (4 bytes/lat 1, 16 bytes/lat 1, 16 bytes/lat 3)
// each driven by a RAM model and a uart_tx model that raises tx_done 10 clocks after tx_dv.
module tb_ram_tx_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] start, abort, tx_active, tx_done, tx_dv, busy, fin;
  logic [2:0] act, mdone, force_act, inj_done;
  logic [3:0] ram_addr [3];
  logic [7:0] ram_q [3];
  logic [7:0] tx_byte [3];
  logic [4:0] bytes_sent [3];
  logic [7:0] mem [3][16];
  logic [7:0] cap [3][$];
  int nchk = 0;
  int nfail = 0;

  typedef struct {
    int         g;
    int         n;
    logic [4:0] sent;
    logic [3:0] last;
  } vec_t;
  vec_t tbl [3];

  always #5 clk = ~clk;
  assign tx_active = act | force_act;
  assign tx_done   = mdone | inj_done;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_i
    logic       a_r, d_r, chk, prev_act;
    int         c_r;
    logic [7:0] held;
    assign act[g]   = a_r;
    assign mdone[g] = d_r;
    ram_tx_streamer #(.ADDR_W(4), .DATA_W(8), .IMG_BYTES(g == 0 ? 4 : 16), .RD_LAT(g == 2 ? 3 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
      .ram_addr(ram_addr[g]), .ram_q(ram_q[g]), .tx_dv(tx_dv[g]), .tx_byte(tx_byte[g]),
      .tx_active(tx_active[g]), .tx_done(tx_done[g]), .busy(busy[g]), .fin(fin[g]),
      .bytes_sent(bytes_sent[g])
    );
    if (g == 2) begin : gen_lat3
      logic [3:0] p0, p1;
      always @(posedge clk) begin
        p0 <= ram_addr[g];
        p1 <= p0;
      end
      assign ram_q[g] = mem[g][p1];
    end else begin : gen_lat1
      assign ram_q[g] = mem[g][ram_addr[g]];
    end
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_r <= 1'b0;
        d_r <= 1'b0;
        c_r <= 0;
      end else begin
        d_r <= 1'b0;
        if (a_r) begin
          if (c_r == 0) begin
            a_r <= 1'b0;
            d_r <= 1'b1;
          end else c_r <= c_r - 1;
        end else if (tx_dv[g]) begin
          a_r <= 1'b1;
          c_r <= 8;
        end
      end
    end
    initial begin
      chk = 1'b0;
      prev_act = 1'b0;
    end
    always @(posedge clk) begin
      if (!rst_n) chk = 1'b0;
      else begin
        if (!busy[g]) chk = 1'b0;
        else if (chk) begin
          check($sformatf("hold%0d", g), tx_byte[g], held);
          if (tx_done[g]) chk = 1'b0;
        end
        if (tx_dv[g]) begin
          check($sformatf("dv_while_active%0d", g), prev_act, 1'b0);
          chk = 1'b1;
          held = tx_byte[g];
          cap[g].push_back(tx_byte[g]);
        end
      end
      prev_act = tx_active[g];
    end
  end

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_fin(input int g);
    for (int i = 0; i < 1000 && !fin[g]; i++) @(negedge clk);
    check($sformatf("fin%0d", g), fin[g], 1'b1);
  endtask

  task automatic wait_cap(input int g, input int n);
    for (int i = 0; i < 200 && cap[g].size() < n; i++) @(negedge clk);
    check("cap_count", cap[g].size(), n);
  endtask

  task automatic check_bytes(input int g, input int n);
    check("strobes", cap[g].size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("byte%0d_%0d", g, i), i < cap[g].size() ? cap[g][i] : 8'hxx, mem[g][i]);
  endtask

  task automatic check_idle_reset(input int g, input string tag);
    check({tag, "_busy"}, busy[g], 1'b0);
    check({tag, "_fin"}, fin[g], 1'b0);
    check({tag, "_addr"}, ram_addr[g], 4'h0);
    check({tag, "_dv"}, tx_dv[g], 1'b0);
    check({tag, "_byte"}, tx_byte[g], 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    start = '0; abort = '0; force_act = '0; inj_done = '0;
    mem[0][0] = 8'hA5; mem[0][1] = 8'h3C; mem[0][2] = 8'hFF; mem[0][3] = 8'h00;
    for (int i = 4; i < 16; i++) mem[0][i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mem[1][i] = 8'(i * 37 + 3);
      mem[2][i] = 8'(i * 53 + 9);
    end
    tbl[0] = '{g: 0, n: 4,  sent: 5'd4,  last: 4'h3};
    tbl[1] = '{g: 1, n: 16, sent: 5'd16, last: 4'hF};
    tbl[2] = '{g: 2, n: 16, sent: 5'd16, last: 4'hF};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_idle_reset(g, "reset");
      check("reset_sent", bytes_sent[g], 5'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // full streams, including RD_LAT=3 alignment and no address wrap at 16 bytes
    for (int k = 0; k < 3; k++) begin
      cap[tbl[k].g].delete();
      pulse_start(tbl[k].g);
      wait_fin(tbl[k].g);
      check("tbl_sent", bytes_sent[tbl[k].g], tbl[k].sent);
      check("tbl_last_addr", ram_addr[tbl[k].g], tbl[k].last);
      check("tbl_busy", busy[tbl[k].g], 1'b0);
      check_bytes(tbl[k].g, tbl[k].n);
    end

    // restart from DONE with latency: fin drops with start, byte one clock later, dv the next
    cap[0].delete();
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("lat_fin_drop", fin[0], 1'b0);
    check("lat_busy", busy[0], 1'b1);
    check("lat_sent_clr", bytes_sent[0], 5'd0);
    check("lat_addr", ram_addr[0], 4'h0);
    @(negedge clk);
    check("lat_byte", tx_byte[0], 8'hA5);
    check("lat_dv_early", tx_dv[0], 1'b0);
    @(negedge clk);
    check("lat_dv", tx_dv[0], 1'b1);
    @(negedge clk);
    check("lat_dv_one", tx_dv[0], 1'b0);
    wait_fin(0);
    check_bytes(0, 4);

    // transmitter held busy: no strobe until tx_active falls
    cap[0].delete();
    force_act[0] = 1'b1;
    pulse_start(0);
    repeat (52) @(negedge clk);
    check("held_no_dv", cap[0].size(), 0);
    check("held_byte", tx_byte[0], 8'hA5);
    force_act[0] = 1'b0;
    wait_cap(0, 1);
    wait_fin(0);
    check("held_sent", bytes_sent[0], 5'd4);
    check_bytes(0, 4);

    // start while busy and spurious tx_done in RD are both ignored
    cap[0].delete();
    pulse_start(0);
    wait_cap(0, 2);
    pulse_start(0);
    check("busy_start_busy", busy[0], 1'b1);
    for (int i = 0; i < 50 && !mdone[0]; i++) @(negedge clk);
    check("spur_done_seen", mdone[0], 1'b1);
    @(negedge clk);
    inj_done[0] = 1'b1;
    @(negedge clk);
    inj_done[0] = 1'b0;
    wait_fin(0);
    check("spur_sent", bytes_sent[0], 5'd4);
    check_bytes(0, 4);

    // abort (with simultaneous start) during WAIT of byte 1
    cap[0].delete();
    pulse_start(0);
    wait_cap(0, 2);
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    start[0] = 1'b0;
    check_idle_reset(0, "abort");
    check("abort_sent", bytes_sent[0], 5'd1);
    repeat (15) @(negedge clk);
    check("abort_sent_hold", bytes_sent[0], 5'd1);
    check("abort_still_idle", busy[0], 1'b0);
    check("abort_strobes", cap[0].size(), 2);
    cap[0].delete();
    pulse_start(0);
    wait_fin(0);
    check("abort_restart_sent", bytes_sent[0], 5'd4);
    check_bytes(0, 4);

    // asynchronous reset mid-frame
    cap[0].delete();
    pulse_start(0);
    wait_cap(0, 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_reset(0, "arst");
    check("arst_sent", bytes_sent[0], 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cap[0].delete();
    @(negedge clk);
    pulse_start(0);
    wait_fin(0);
    check("arst_restart_sent", bytes_sent[0], 5'd4);
    check_bytes(0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
